// File: rtl/dpsk_demod_core.sv
// dpsk_demod_core: delay-and-multiply DBPSK demodulator with rate classification and bit strobe; DEMOD_PRODUCT_TAP_EN enables the mode-2 product tap
module dpsk_demod_core #(
  parameter int DW      = 10,
  parameter int DELAY   = 8,
  parameter int THRESH  = 200,
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 5500,
  parameter int R10_LO  = 3100,
  parameter int R10_HI  = 3300,
  parameter int R8_LO   = 3900,
  parameter int R8_HI   = 4100,
  parameter int R6_LO   = 5233,
  parameter int R6_HI   = 5433
) (
  input  logic          clk_32m,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          sample_en,
  input  logic          rate_clr,
  input  logic [DW-1:0] ad_data,
  output logic [DW-1:0] demod_out,
  output logic [7:0]    freq,
  output logic          locked,
  output logic          bit_out,
  output logic          bit_valid
);
  localparam int PW = 2 * DW;
  localparam logic signed [PW-1:0] TH = PW'(THRESH);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONES = '1;
  logic signed [DW-1:0] s_q, s_d;
  logic signed [DW-1:0] dl_q [DELAY];
  logic signed [DW-1:0] dl_d [DELAY];
  logic signed [PW-1:0] p_q, p_d;
  logic wave_q, wave_d, wave_r_q, wave_r_d, code_q, code_d, sat_q, sat_d;
  logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic [CNT_W-1:0] ic_q, ic_d, mi_q, mi_d, ph_q, ph_d;
  logic [7:0] freq_q, freq_d;
  logic [DW-1:0] dm_q, dm_d, tap;
  logic tr, lock;
  always_comb begin
    s_d = sample_en ? {~ad_data[DW-1], ad_data[DW-2:0]} : s_q;
    dl_d[0] = sample_en ? s_q : dl_q[0];
    for (int i = 1; i < DELAY; i++) dl_d[i] = sample_en ? dl_q[i-1] : dl_q[i];
    p_d = s_q * dl_q[DELAY-1];
    wave_d = (p_q >= TH) ? 1'b1 : (p_q <= -TH) ? 1'b0 : wave_q;
    wave_r_d = wave_q;
    tr = wave_q & ~wave_r_q;
    code_d = code_q ^ tr;
    ic_d = tr ? '0 : (ic_q > TO) ? ic_q : ic_q + 1'b1;
    sat_d = tr ? 1'b0 : ((ic_q > TO) | sat_q);
    mi_d = rate_clr ? ONES : (tr && !sat_q && ic_q <= mi_q) ? ic_q : mi_q;
    freq_d = rate_clr ? 8'd0 :
             (mi_q >= CNT_W'(R10_LO) && mi_q <= CNT_W'(R10_HI)) ? 8'd10 :
             (mi_q >= CNT_W'(R8_LO) && mi_q <= CNT_W'(R8_HI)) ? 8'd8 :
             (mi_q >= CNT_W'(R6_LO) && mi_q <= CNT_W'(R6_HI)) ? 8'd6 : freq_q;
    lock = freq_q != 8'd0;
    ph_d = (rate_clr || tr || !lock || ph_q == mi_q - 1'b1) ? '0 : ph_q + 1'b1;
    bit_valid_d = en && lock && !rate_clr && ph_q == (mi_q >> 1);
    bit_out_d = bit_valid_d ? code_q : bit_out_q;
`ifdef DEMOD_PRODUCT_TAP_EN
    tap = (mode == 2'd2) ? p_q[PW-1 -: DW] : ad_data;
`else
    tap = ad_data;
`endif
    dm_d = !en ? '0 : (mode == 2'd1) ? {DW{code_q}} : tap;
  end
  always_ff @(posedge clk_32m) begin
    if (!rst_n) begin
      s_q <= '0;
      dl_q <= '{default: '0};
      p_q <= '0;
      wave_q <= 1'b0;
      wave_r_q <= 1'b0;
      code_q <= 1'b0;
      ic_q <= '0;
      sat_q <= 1'b0;
      mi_q <= ONES;
      freq_q <= '0;
      ph_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
      dm_q <= '0;
    end else begin
      s_q <= s_d;
      dl_q <= dl_d;
      p_q <= p_d;
      wave_q <= wave_d;
      wave_r_q <= wave_r_d;
      code_q <= code_d;
      ic_q <= ic_d;
      sat_q <= sat_d;
      mi_q <= mi_d;
      freq_q <= freq_d;
      ph_q <= ph_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      dm_q <= dm_d;
    end
  end
  assign demod_out = dm_q;
  assign freq = freq_q;
  assign locked = lock;
  assign bit_out = bit_out_q;
  assign bit_valid = bit_valid_q;
endmodule

// File: tb/tb_dpsk_demod_core.sv
// tb_dpsk_demod_core: self-checking bench for dpsk_demod_core with output and recovered-bit scoreboards
`timescale 1ns/1ps
module tb_dpsk_demod_core;
`ifdef DEMOD_PRODUCT_TAP_EN
  localparam bit TAP = 1'b1;
`else
  localparam bit TAP = 1'b0;
`endif
  typedef struct {
    logic en;
    logic [1:0] mode;
    logic [9:0] ad;
    logic [9:0] exp;
  } vec_t;
  logic clk_32m = 1'b0, rst_n = 1'b0, en = 1'b0, sample_en = 1'b0, rate_clr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [9:0] ad_data = 10'd0;
  logic [9:0] demod_out;
  logic [7:0] freq;
  logic locked, bit_out, bit_valid;
  int total = 0, bad = 0;
  int n = 0, phs = 0, cyc = 0, prev_t = 0, run_cnt = 0, sp = 0;
  bit car = 0, chk_bits = 0, chk_dm = 0, en_nx = 1, code_exp = 0;
  logic [9:0] dq [$];
  bit bq [$];
  int cosv [8] = '{400, 283, 0, -283, -400, -283, 0, 283};
  vec_t tv [8];
  dpsk_demod_core dut (
    .clk_32m(clk_32m), .rst_n(rst_n), .en(en), .mode(mode), .sample_en(sample_en),
    .rate_clr(rate_clr), .ad_data(ad_data), .demod_out(demod_out), .freq(freq),
    .locked(locked), .bit_out(bit_out), .bit_valid(bit_valid)
  );
  always #15.625 clk_32m = ~clk_32m;
  always @(posedge clk_32m) cyc <= cyc + 1;
  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic ceq(input string nm, input int act, input int exp);
    chk(nm, act == exp, act, exp);
  endtask
  task automatic tick();
    bit b;
    int d;
    @(negedge clk_32m);
    if (chk_bits && bit_valid) begin
      if (bq.size() == 0) chk("bit_extra", 1'b0, 1, 0);
      else begin
        b = bq.pop_front();
        ceq("bit_out", bit_out, b);
        if (mode == 2'd1) ceq("bit_demod", demod_out, b ? 10'h3FF : 10'h000);
        d = cyc - prev_t;
        if (run_cnt >= 2) chk("bit_ivl", d >= sp - 1 && d <= sp + 1, d, sp);
        run_cnt++;
        prev_t = cyc;
      end
    end
    if (chk_dm && dq.size() > 0) ceq("dm_en", demod_out, dq.pop_front());
    en = en_nx;
    if (car) begin
      ad_data = 10'(512 + cosv[(n + phs) % 8]);
      n++;
    end
    if (chk_dm) dq.push_back(en ? ad_data : 10'd0);
  endtask
  task automatic run(input int k);
    repeat (k) tick();
  endtask
  task automatic flip(input bit push);
    phs ^= 4;
    code_exp = !code_exp;
    if (push) bq.push_back(code_exp);
  endtask
  task automatic pulse_clr();
    rate_clr = 1'b1;
    tick();
    rate_clr = 1'b0;
  endtask
  initial begin
    tv = '{
      '{1'b1, 2'd0, 10'h155, 10'h155},
      '{1'b1, 2'd3, 10'h2AA, 10'h2AA},
      '{1'b1, 2'd1, 10'h3FF, 10'h000},
      '{1'b0, 2'd0, 10'h3FF, 10'h000},
      '{1'b1, 2'd2, 10'h2C3, (TAP ? 10'h000 : 10'h2C3)},
      '{1'b0, 2'd2, 10'h1A5, 10'h000},
      '{1'b1, 2'd0, 10'h3FF, 10'h3FF},
      '{1'b0, 2'd1, 10'h000, 10'h000}
    };
    en = 1'b1;
    ad_data = 10'h155;
    repeat (4) @(negedge clk_32m);
    ceq("rst_demod", demod_out, 0);
    ceq("rst_freq", freq, 0);
    ceq("rst_locked", locked, 0);
    ceq("rst_bit_out", bit_out, 0);
    ceq("rst_bit_valid", bit_valid, 0);
    ceq("rst_mi", dut.mi_q, 13'h1fff);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_32m);
      if (i > 0) ceq($sformatf("tv%0d", i - 1), demod_out, dq.pop_front());
      en = tv[i].en;
      mode = tv[i].mode;
      ad_data = tv[i].ad;
      dq.push_back(tv[i].exp);
    end
    @(negedge clk_32m);
    ceq("tv7", demod_out, dq.pop_front());
    ceq("tv_freq", freq, 0);
    ceq("tv_bit_valid", bit_valid, 0);
    mode = 2'd2;
    en = 1'b1;
    sample_en = 1'b1;
    ad_data = 10'h3FF;
    repeat (16) @(negedge clk_32m);
    ceq("m2_tap", demod_out, TAP ? 10'h0FF : 10'h3FF);
    mode = 2'd1;
    sample_en = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk_32m);
    ceq("rst2_demod", demod_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_32m);
    ceq("code_rst", demod_out, 0);
    sample_en = 1'b1;
    en_nx = 1'b1;
    car = 1'b1;
    code_exp = 1'b1;
    run(6000);
    ceq("startup_freq", freq, 0);
    pulse_clr();
    run(100);
    chk_bits = 1'b1;
    run_cnt = 0;
    sp = 3200;
    flip(1'b0);
    run(40);
    ceq("r10_mi_sat", dut.mi_q, 13'h1fff);
    ceq("r10_freq_f1", freq, 0);
    run(sp - 40);
    for (int k = 0; k < 4; k++) begin
      flip(1'b1);
      run(40);
      ceq("r10_freq", freq, 10);
      ceq("r10_locked", locked, 1);
      run(k == 3 ? 2960 : sp - 40);
    end
    ceq("r10_bits_left", bq.size(), 0);
    pulse_clr();
    run(2);
    ceq("clr_freq", freq, 0);
    ceq("clr_locked", locked, 0);
    run(997);
    run_cnt = 0;
    sp = 4000;
    for (int k = 0; k < 3; k++) begin
      flip(1'b1);
      run(40);
      ceq("r8_freq", freq, 8);
      ceq("r8_locked", locked, 1);
      run(k == 2 ? 2960 : sp - 40);
    end
    ceq("r8_bits_left", bq.size(), 0);
    pulse_clr();
    run(2);
    ceq("clr8_freq", freq, 0);
    ceq("clr8_locked", locked, 0);
    run(2330);
    run_cnt = 0;
    sp = 5333;
    for (int k = 0; k < 3; k++) begin
      flip(1'b1);
      run(40);
      ceq("r6_freq", freq, 6);
      run(k == 2 ? 2960 : sp - 40);
    end
    ceq("r6_bits_left", bq.size(), 0);
    chk_bits = 1'b0;
    mode = 2'd0;
    chk_dm = 1'b1;
    for (int i = 0; i < 64; i++) begin
      en_nx = 1'($urandom_range(0, 1));
      tick();
      ceq("en_freq", freq, 6);
    end
    en_nx = 1'b1;
    tick();
    chk_dm = 1'b0;
    dq.delete();
    mode = 2'd1;
    pulse_clr();
    run(2);
    ceq("gap_clr_mi", dut.mi_q, 13'h1fff);
    run(6000);
    flip(1'b0);
    run(40);
    ceq("gap_mi_hold", dut.mi_q, 13'h1fff);
    run(2460);
    flip(1'b0);
    run(40);
    chk("gap_mi_upd", dut.mi_q >= 2498 && dut.mi_q <= 2500, dut.mi_q, 2499);
    ceq("gap_freq", freq, 0);
    run(2460);
    flip(1'b0);
    run(40);
    ceq("gap_freq2", freq, 0);
    ceq("gap_locked", locked, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
